branch_flag_ctrl: RTL and testbench
===================================

# branch_flag_ctrl

Sequencing controller for the ALU's condition outputs in the pipelined 64-bit core. Holds the architectural NZCV flag register, updated from the ALU result and zero-detect outputs on flag-setting instructions. Resolves unconditional branches, B.cond, CBZ and CBNZ in the execute stage. Issues a registered PC redirect and a two-cycle front-end flush for taken branches.

## Interface
Parameters:
- WIDTH, 64: PC / branch-target width.
- SQUASH_CYCLES, 2: number of cycles `flush` is held after a taken branch, and the length of the window in which EX inputs are ignored (1..3).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  pipeline stall; freezes flag and branch acceptance.
- alu_valid  input  1  EX stage holds a real instruction.
- set_flags  input  1  instruction writes NZCV (ADDS/SUBS/ANDS…).
- alu_n, alu_z, alu_c, alu_v  input  1 each  ALU negative, zero (from zero detector), carry, overflow.
- br_valid  input  1  EX instruction is a branch; meaningful only with alu_valid.
- br_type  input  2  00 B (unconditional), 01 B.cond, 10 CBZ, 11 CBNZ.
- br_cond  input  4  condition code for B.cond.
- reg_zero  input  1  zero-detect of the CBZ/CBNZ register operand.
- br_target  input  WIDTH  computed branch target.
- flags_q  output  4  registered NZCV, bit 3 = N … bit 0 = V.
- redirect_valid  output  1  one-cycle pulse: fetch PC must load redirect_pc.
- redirect_pc  output  WIDTH  registered target.
- flush  output  1  squash IF/ID.

## Operation
- Accept condition: `alu_valid & ~stall & (squash_cnt == 0)`. If the condition is false, the cycle's set_flags and branch inputs have no effect.
- Flag update on accept with set_flags: `flags_q <= {alu_n, alu_z, alu_c, alu_v}`.
- B.cond evaluation uses the effective flags:
  - When the same instruction also asserts set_flags, use the incoming ALU flags (bypass).
  - Otherwise use flags_q.
- Condition codes:
  - 0 EQ Z; 1 NE !Z
  - 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N
  - 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !(C&!Z)
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 and 15: always.
- Taken when:
  - type 00: always;
  - type 01: cond true;
  - type 10: reg_zero;
  - type 11: !reg_zero.
- A taken accepted branch:
  - registers redirect_pc <= br_target;
  - sets redirect_valid for the next cycle;
  - loads squash_cnt <= SQUASH_CYCLES.
- Not-taken branches produce no output change.
- State machine:
  - IDLE (squash_cnt = 0) → SQUASH on a taken branch.
  - SQUASH decrements squash_cnt each cycle and returns to IDLE at 0.
  - `flush = (squash_cnt != 0)`.
- stall:
  - holds flags_q, squash_cnt and redirect_pc.
  - redirect_valid is still a single pulse and is not extended by stall.
- redirect_pc holds its last value until the next taken branch.

## Timing
- Reset values: flags_q = 4'b0000, redirect_valid = 0, redirect_pc = 0, flush = 0, squash_cnt = 0.
- Reset wins over every input in the same cycle. Reset during SQUASH clears flush on the next edge.
- Taken branch accepted at edge-cycle t:
  - redirect_valid = 1 and redirect_pc valid during t+1 only;
  - flush = 1 during t+1 … t+SQUASH_CYCLES;
  - inputs ignored in those cycles, including set_flags.
- Flag write latency 1 cycle: set_flags at t is visible on flags_q at t+1. A B.cond at t sees it through the bypass; a B.cond at t+1 sees it through flags_q.
- Back-to-back taken branches are impossible: the second one falls in the squash window and is discarded.
- Stall during SQUASH extends flush by the number of stalled cycles.

## Test plan
- Reset, then idle → flags_q=0000, flush=0, redirect_valid=0. Then SUBS with n=0,z=1,c=1,v=0 → flags_q=0110 next cycle.
- flags_q=0110, B.cond cond=0 (EQ) target 0x400 → redirect_valid pulse with redirect_pc=0x400 at t+1; flush high t+1,t+2. Repeat with cond=1 (NE) → no redirect, no flush.
- Same-cycle bypass: flags_q=0000, set_flags with z=1 plus B.cond EQ target 0x80 → taken, redirect_pc=0x80, flags_q=0100.
- CBZ with reg_zero=1, target 0x1000 → taken. CBNZ with reg_zero=1 → not taken. In both cases flags_q is unchanged.
- Squash window: taken B at t; at t+1, SUBS with set_flags and z=0 plus B to 0x2000 → ignored. flags_q and redirect_pc (first target) are unchanged, and there is no second redirect_valid pulse.
- Stall/reset: taken branch, then stall at t+1 → flush held through t+3. A separate run with reset asserted at t+1 → flush=0, redirect_pc=0 at t+2.

Source files
------------

// File: rtl/branch_flag_ctrl.sv
// Execute-stage flag register and branch resolver: owns NZCV, resolves B/B.cond/CBZ/CBNZ,
// and issues a registered PC redirect followed by a counted front-end flush window.
module branch_flag_ctrl #(
  parameter int WIDTH         = 64,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             alu_valid,
  input  logic             set_flags,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [3:0]       br_cond,
  input  logic             reg_zero,
  input  logic [WIDTH-1:0] br_target,
  output logic [3:0]       flags_q,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush,
  output logic [0:0]       dbg_state
);

  localparam int CNT_W = $clog2(SQUASH_CYCLES + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  localparam logic [1:0] BR_B    = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_CBZ  = 2'b10;
  localparam logic [1:0] BR_CBNZ = 2'b11;

  logic [3:0]       r_flags;
  logic             r_redirect_valid;
  logic [WIDTH-1:0] r_redirect_pc;
  logic [CNT_W-1:0] r_squash_cnt;

  logic             w_accept;
  logic [3:0]       w_alu_flags;
  logic [3:0]       w_eff_flags;
  logic             w_n, w_z, w_c, w_v;
  logic             w_cond_true;
  logic             w_taken;
  logic [0:0]       w_state;

  assign w_state     = (r_squash_cnt != '0) ? ST_SQUASH : ST_IDLE;
  assign w_accept    = alu_valid & ~stall & (w_state == ST_IDLE);
  assign w_alu_flags = {alu_n, alu_z, alu_c, alu_v};
  // Same-instruction flag write is forwarded so B.cond never sees stale NZCV.
  assign w_eff_flags = set_flags ? w_alu_flags : r_flags;
  assign {w_n, w_z, w_c, w_v} = w_eff_flags;

  always_comb begin
    w_cond_true = 1'b0;
    case (br_cond)
      4'd0:  w_cond_true = w_z;
      4'd1:  w_cond_true = ~w_z;
      4'd2:  w_cond_true = w_c;
      4'd3:  w_cond_true = ~w_c;
      4'd4:  w_cond_true = w_n;
      4'd5:  w_cond_true = ~w_n;
      4'd6:  w_cond_true = w_v;
      4'd7:  w_cond_true = ~w_v;
      4'd8:  w_cond_true = w_c & ~w_z;
      4'd9:  w_cond_true = ~(w_c & ~w_z);
      4'd10: w_cond_true = (w_n == w_v);
      4'd11: w_cond_true = (w_n != w_v);
      4'd12: w_cond_true = ~w_z & (w_n == w_v);
      4'd13: w_cond_true = w_z | (w_n != w_v);
      default: w_cond_true = 1'b1;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (br_type)
      BR_B:    w_taken = 1'b1;
      BR_COND: w_taken = w_cond_true;
      BR_CBZ:  w_taken = reg_zero;
      BR_CBNZ: w_taken = ~reg_zero;
      default: w_taken = 1'b0;
    endcase
  end

  // redirect_valid is a single-cycle pulse with no back-pressure: fetch must load
  // redirect_pc in the cycle it is high; stall never stretches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags          <= 4'b0000;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_squash_cnt     <= '0;
    end else begin
      r_redirect_valid <= 1'b0;
      if (w_accept && set_flags)
        r_flags <= w_alu_flags;
      if (w_accept && br_valid && w_taken) begin
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= br_target;
        r_squash_cnt     <= CNT_W'(SQUASH_CYCLES);
      end else if (w_state == ST_SQUASH && !stall) begin
        r_squash_cnt <= r_squash_cnt - CNT_W'(1);
      end
    end
  end

  assign flags_q        = r_flags;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = (w_state == ST_SQUASH);
  assign dbg_state      = w_state;

endmodule

// File: tb/tb_branch_flag_ctrl.sv
// Bench for branch_flag_ctrl: directed scenarios then random traffic; a reference model
// pushes expected post-edge outputs into a queue that a negedge monitor pops and compares.
module tb_branch_flag_ctrl;

  localparam int WIDTH = 64;
  localparam int SQ    = 2;
  localparam int EW    = 4 + 1 + WIDTH + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic             alu_valid = 1'b0;
  logic             set_flags = 1'b0;
  logic             alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
  logic             br_valid = 1'b0;
  logic [1:0]       br_type = 2'b00;
  logic [3:0]       br_cond = 4'd0;
  logic             reg_zero = 1'b0;
  logic [WIDTH-1:0] br_target = '0;
  logic [3:0]       flags_q;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             flush;
  logic [0:0]       dbg_state;

  branch_flag_ctrl #(.WIDTH(WIDTH), .SQUASH_CYCLES(SQ)) dut (
    .clk(clk), .reset(reset), .stall(stall), .alu_valid(alu_valid),
    .set_flags(set_flags), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond), .reg_zero(reg_zero),
    .br_target(br_target), .flags_q(flags_q), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0]       m_flags = 4'b0000;
  logic             m_rv = 1'b0;
  logic [WIDTH-1:0] m_pc = '0;
  int               m_blocked = 0;  // unstalled cycles left in which EX inputs are dropped

  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Conditions come in true/inverted pairs; 14/15 are always true.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c >> 1)
      0: r = z;
      1: r = cf;
      2: r = n;
      3: r = v;
      4: r = cf && !z;
      5: r = (n == v);
      6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if ((c >> 1) != 7 && c[0]) r = !r;
    return r;
  endfunction

  function automatic bit br_taken(input logic [1:0] t, input logic [3:0] c,
                                  input bit rz, input logic [3:0] f);
    if (t == 0) return 1'b1;
    if (t == 1) return cond_holds(c, f);
    if (t == 2) return rz;
    return !rz;
  endfunction

  task automatic model_step();
    logic [3:0] eff;
    bit acc;
    if (reset) begin
      m_flags = 4'b0000; m_rv = 1'b0; m_pc = '0; m_blocked = 0;
    end else begin
      acc = alu_valid && !stall && (m_blocked == 0);
      eff = set_flags ? {alu_n, alu_z, alu_c, alu_v} : m_flags;
      m_rv = 1'b0;
      if (acc && set_flags) m_flags = {alu_n, alu_z, alu_c, alu_v};
      if (acc && br_valid && br_taken(br_type, br_cond, reg_zero, eff)) begin
        m_pc = br_target; m_rv = 1'b1; m_blocked = SQ;
      end else if (m_blocked > 0 && !stall) begin
        m_blocked = m_blocked - 1;
      end
    end
    exp_q.push_back({m_flags, m_rv, m_pc, (m_blocked > 0)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit rst, input bit stl, input bit av, input bit sf,
                       input logic [3:0] nzcv, input bit bv, input logic [1:0] bt,
                       input logic [3:0] bc, input bit rz, input logic [WIDTH-1:0] tgt);
    @(negedge clk);
    #1;
    reset = rst; stall = stl; alu_valid = av; set_flags = sf;
    {alu_n, alu_z, alu_c, alu_v} = nzcv;
    br_valid = bv; br_type = bt; br_cond = bc; reg_zero = rz; br_target = tgt;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 4'h0, 0, 2'd0, 4'd0, 0, '0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 4'h0, 0, 2'd0, 4'd0, 0, '0);
    cycle(1, 0, 0, 0, 4'h0, 0, 2'd0, 4'd0, 0, '0);
  endtask

  task automatic rand_cycle();
    logic [WIDTH-1:0] tgt;
    tgt = {$urandom(), $urandom()};
    cycle($urandom_range(0, 49) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 5) != 0,
          $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 4,
          2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, tgt);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic check_bits(input string name, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_bits("flags_q", WIDTH'(flags_q), WIDTH'(e[EW-1 -: 4]));
      check_bits("redirect_valid", WIDTH'(redirect_valid), WIDTH'(e[WIDTH+1]));
      check_bits("redirect_pc", redirect_pc, e[WIDTH:1]);
      check_bits("flush", WIDTH'(flush), WIDTH'(e[0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    idle(1);
    // SUBS n0 z1 c1 v0 -> 0110
    cycle(0, 0, 1, 1, 4'b0110, 0, 2'd0, 4'd0, 0, '0);
    idle(1);
    // B.cond EQ taken, then NE not taken
    cycle(0, 0, 1, 0, 4'h0, 1, 2'd1, 4'd0, 0, 64'h400);
    idle(3);
    cycle(0, 0, 1, 0, 4'h0, 1, 2'd1, 4'd1, 0, 64'h500);
    idle(2);
    // Clear flags, then same-cycle bypass: set z plus B.cond EQ
    cycle(0, 0, 1, 1, 4'b0000, 0, 2'd0, 4'd0, 0, '0);
    cycle(0, 0, 1, 1, 4'b0100, 1, 2'd1, 4'd0, 0, 64'h80);
    idle(3);
    // CBZ taken, CBNZ not taken
    cycle(0, 0, 1, 0, 4'h0, 1, 2'd2, 4'd0, 1, 64'h1000);
    idle(3);
    cycle(0, 0, 1, 0, 4'h0, 1, 2'd3, 4'd0, 1, 64'h2000);
    idle(2);
    // Squash window drops flag write and second branch
    cycle(0, 0, 1, 0, 4'h0, 1, 2'd0, 4'd0, 0, 64'h3000);
    cycle(0, 0, 1, 1, 4'b1000, 1, 2'd0, 4'd0, 0, 64'h2000);
    idle(3);
    // Stall during squash extends flush
    cycle(0, 0, 1, 0, 4'h0, 1, 2'd0, 4'd0, 0, 64'h4000);
    cycle(0, 1, 0, 0, 4'h0, 0, 2'd0, 4'd0, 0, '0);
    idle(4);
    // Reset during squash
    cycle(0, 0, 1, 0, 4'h0, 1, 2'd0, 4'd0, 0, 64'h5000);
    cycle(1, 0, 0, 0, 4'h0, 0, 2'd0, 4'd0, 0, '0);
    idle(2);
    // Every condition code against random flags
    for (int c = 0; c < 16; c++) begin
      cycle(0, 0, 1, 1, 4'($urandom_range(0, 15)), 0, 2'd0, 4'd0, 0, '0);
      cycle(0, 0, 1, 0, 4'h0, 1, 2'd1, 4'(c), 0, 64'(c * 16 + 8));
      idle(2);
    end
    for (int i = 0; i < 2000; i++) rand_cycle();
    idle(1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain got=%0d pending exp=0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
